// File: rtl/load_store_unit_if.sv
// CPU request/response and word-memory port signals of the load/store unit.
// slave is the unit's own view; master is the CPU/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [31:0] req_rt_old;
  logic        load_valid;
  logic [31:0] load_data;
  logic        store_done;
  logic        error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_clock_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_op, req_address, req_store_data, req_rt_old, mem_read_data,
    output req_ready, load_valid, load_data, store_done, error,
           mem_address, mem_read, mem_write, mem_clock_enable, mem_write_data
  );

  modport master (
    output req_valid, req_op, req_address, req_store_data, req_rt_old, mem_read_data,
    input  req_ready, load_valid, load_data, store_done, error,
           mem_address, mem_read, mem_write, mem_clock_enable, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS load/store unit: turns byte/halfword/word/LWL/LWR requests into word-aligned
// big-endian accesses, using read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [2:0] {
    IDLE, LOAD, DONE_L, STORE_W, RMW_RD, RMW_WR, DONE_S, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        lv_q, lv_d;
  logic        sd_q, sd_d;
  logic        err_q, err_d;

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] k);
    case (op)
      OP_LH, OP_LHU, OP_SH: return k[0];
      OP_LW, OP_SW:         return (k != 2'd0);
      default:              return 1'b0;
    endcase
  endfunction

  // Shifting left by 8k brings lane k to the top byte, so sub-word fields read from [31:...].
  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] k,
                                              input logic [31:0] word, input logic [31:0] rt_old);
    logic [31:0] up;
    logic [4:0]  sh_l;
    logic [4:0]  sh_r;
    up   = word << {k, 3'b000};
    sh_l = {k, 3'b000};
    sh_r = {~k, 3'b000};
    case (op)
      OP_LB:   return {{24{up[31]}}, up[31:24]};
      OP_LBU:  return {24'h0, up[31:24]};
      OP_LH:   return {{16{up[31]}}, up[31:16]};
      OP_LHU:  return {16'h0, up[31:16]};
      OP_LWL:  return up | (rt_old & ((32'h1 << sh_l) - 32'h1));
      OP_LWR:  return (word >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [3:0] op, input logic [1:0] k,
                                              input logic [31:0] old, input logic [31:0] sd);
    logic [31:0] mask;
    logic [31:0] data;
    if (op == OP_SB) begin
      mask = 32'hFF00_0000 >> {k, 3'b000};
      data = {4{sd[7:0]}};
    end else begin
      mask = 32'hFFFF_0000 >> {k, 3'b000};
      data = {2{sd[15:0]}};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rt_old_d    = rt_old_q;
    merge_d     = merge_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          addr_d   = bus.req_address;
          sdata_d  = bus.req_store_data;
          rt_old_d = bus.req_rt_old;
          if (!legal_op(bus.req_op) || (bus.req_address >= 32'(MEM_BYTES)) ||
              misaligned(bus.req_op, bus.req_address[1:0])) begin
            state_d = ERR;
          end else begin
            case (bus.req_op)
              OP_SW:        state_d = STORE_W;
              OP_SB, OP_SH: state_d = RMW_RD;
              default:      state_d = LOAD;
            endcase
          end
        end
      end
      LOAD: begin
        load_data_d = load_result(op_q, addr_q[1:0], bus.mem_read_data, rt_old_q);
        state_d     = DONE_L;
      end
      STORE_W: state_d = DONE_S;
      RMW_RD: begin
        merge_d = bus.mem_read_data;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = DONE_S;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    ready_d = (state_d == IDLE);
    rd_d    = (state_d == LOAD) || (state_d == RMW_RD);
    wr_d    = (state_d == STORE_W) || (state_d == RMW_WR);
    lv_d    = (state_d == DONE_L);
    sd_d    = (state_d == DONE_S);
    err_d   = (state_d == ERR);
    if (state_d == STORE_W)
      wdata_d = sdata_d;
    else if (state_d == RMW_WR)
      wdata_d = store_merge(op_q, addr_q[1:0], merge_d, sdata_q);
    else
      wdata_d = 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= 4'h0;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      rt_old_q    <= 32'h0;
      merge_q     <= 32'h0;
      load_data_q <= 32'h0;
      wdata_q     <= 32'h0;
      ready_q     <= 1'b1;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      lv_q        <= 1'b0;
      sd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rt_old_q    <= rt_old_d;
      merge_q     <= merge_d;
      load_data_q <= load_data_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      lv_q        <= lv_d;
      sd_q        <= sd_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.load_valid       = lv_q;
  assign bus.load_data        = load_data_q;
  assign bus.store_done       = sd_q;
  assign bus.error            = err_q;
  assign bus.mem_address      = {addr_q[31:2], 2'b00};
  assign bus.mem_read         = rd_q;
  assign bus.mem_write        = wr_q;
  assign bus.mem_clock_enable = wr_q;
  assign bus.mem_write_data   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide big-endian memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(4096)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  assign bus.mem_read_data = mem[bus.mem_address[11:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;

  int n_sd = 0, n_strobe = 0, n_viol = 0;
  always @(negedge clk) begin
    if (bus.store_done) n_sd++;
    if (bus.mem_read || bus.mem_write) n_strobe++;
    if ((int'(bus.load_valid) + int'(bus.store_done) + int'(bus.error)) > 1 ||
        (bus.mem_read && bus.mem_write) || (bus.mem_clock_enable !== bus.mem_write))
      n_viol++;
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rt);
    int w = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_wait req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_address = a;
    bus.req_store_data = sd; bus.req_rt_old = rt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.load_valid, bus.store_done, bus.error, bus.mem_read, bus.mem_write} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b required 100000",
        {bus.req_ready, bus.load_valid, bus.store_done, bus.error, bus.mem_read, bus.mem_write});
    end
    checks++;
    if (bus.load_data !== 32'h0 || bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_data load_data=%h mem_address=%h wdata=%h required 0",
        bus.load_data, bus.mem_address, bus.mem_write_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [4] = '{4'd0, 4'd1, 4'd2, 4'd2};
    logic [31:0] adrs [4] = '{32'h20, 32'h20, 32'h20, 32'h22};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    mem[8] = 32'h80FF_7F01;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], adrs[i], 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b1 || bus.load_valid !== 1'b0 ||
          bus.mem_address !== 32'h20) begin
        errors++; $display("FAIL load%0d_cyc1 ready=%b rd=%b lv=%b addr=%h required 0 1 0 00000020",
          i, bus.req_ready, bus.mem_read, bus.load_valid, bus.mem_address);
      end
      @(negedge clk);
      checks++;
      if (bus.load_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.load_data !== exps[i]) begin
        errors++; $display("FAIL load%0d_result lv=%b ready=%b data=%h required 1 0 %h",
          i, bus.load_valid, bus.req_ready, bus.load_data, exps[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.load_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.load_data !== exps[i]) begin
        errors++; $display("FAIL load%0d_after lv=%b ready=%b data=%h required 0 1 %h",
          i, bus.load_valid, bus.req_ready, bus.load_data, exps[i]);
      end
    end
  endtask

  task automatic test_rmw_store();
    int cyc;
    mem[4] = 32'h1122_3344;
    send(4'd8, 32'h12, 32'hAABB_CCDD, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.store_done !== 1'b0) begin
      errors++; $display("FAIL sb_rmw_rd rd=%b wr=%b sd=%b required 1 0 0", bus.mem_read, bus.mem_write, bus.store_done);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_write_data !== 32'h1122_DD44 || bus.mem_address !== 32'h10) begin
      errors++; $display("FAIL sb_rmw_wr wr=%b wdata=%h addr=%h required 1 1122dd44 00000010",
        bus.mem_write, bus.mem_write_data, bus.mem_address);
    end
    @(negedge clk);
    checks++;
    if (bus.store_done !== 1'b1 || mem[4] !== 32'h1122_DD44) begin
      errors++; $display("FAIL sb_done sd=%b word=%h required 1 1122dd44", bus.store_done, mem[4]);
    end
    send(4'd9, 32'h10, 32'h0000_BEEF, 32'h0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.store_done !== 1'b1 && cyc < 10);
    checks++;
    if (bus.store_done !== 1'b1 || cyc != 3 || mem[4] !== 32'hBEEF_DD44) begin
      errors++; $display("FAIL sh_done sd=%b cycles=%0d word=%h required 1 3 beefdd44", bus.store_done, cyc, mem[4]);
    end
  endtask

  task automatic test_lwl_lwr();
    logic [3:0]  ops  [3] = '{4'd5, 4'd6, 4'd6};
    logic [31:0] adrs [3] = '{32'h11, 32'h11, 32'h13};
    logic [31:0] exps [3] = '{32'h2233_44BE, 32'hCAFE_1122, 32'h1122_3344};
    int cyc;
    mem[4] = 32'h1122_3344;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], adrs[i], 32'h0, 32'hCAFE_BABE);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (bus.load_valid !== 1'b1 && cyc < 10);
      checks++;
      if (bus.load_valid !== 1'b1 || cyc != 2 || bus.load_data !== exps[i]) begin
        errors++; $display("FAIL lwlr%0d lv=%b cycles=%0d data=%h required 1 2 %h",
          i, bus.load_valid, cyc, bus.load_data, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops  [4] = '{4'd9, 4'd4, 4'd0, 4'd7};
    logic [31:0] adrs [4] = '{32'h13, 32'h0E, 32'h1000, 32'h10};
    int s0;
    mem[3] = 32'h3333_3333;
    mem[4] = 32'h1122_3344;
    mem[0] = 32'h0000_0000;
    s0 = n_strobe;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], adrs[i], 32'hFFFF_FFFF, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.error !== 1'b1 || bus.req_ready !== 1'b0 || bus.load_valid !== 1'b0 || bus.store_done !== 1'b0) begin
        errors++; $display("FAIL err%0d_pulse err=%b ready=%b lv=%b sd=%b required 1 0 0 0",
          i, bus.error, bus.req_ready, bus.load_valid, bus.store_done);
      end
      @(negedge clk);
      checks++;
      if (bus.error !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL err%0d_after err=%b ready=%b required 0 1", i, bus.error, bus.req_ready);
      end
    end
    checks++;
    if (n_strobe != s0 || mem[3] !== 32'h3333_3333 || mem[4] !== 32'h1122_3344 || mem[0] !== 32'h0) begin
      errors++; $display("FAIL err_no_access strobes=%0d words=%h %h %h required 0 33333333 11223344 00000000",
        n_strobe - s0, mem[3], mem[4], mem[0]);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int sd0;
    mem[4] = 32'h1122_3344;
    sd0 = n_sd;
    send(4'd8, 32'h10, 32'h0000_0055, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rd rd=%b required 1", bus.mem_read);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_read, bus.mem_write, bus.store_done, bus.error} !== 5'b10000) begin
      errors++; $display("FAIL rst_mid_now got %b required 10000",
        {bus.req_ready, bus.mem_read, bus.mem_write, bus.store_done, bus.error});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mem[4] !== 32'h1122_3344 || n_sd != sd0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after word=%h store_dones=%0d ready=%b required 11223344 0 1",
        mem[4], n_sd - sd0, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  r_op   [8];
    logic [31:0] r_addr [8];
    logic [31:0] r_data [8];
    logic        q_load [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    int idx = 0, done = 0, cyc = 0;
    for (int i = 0; i < 8; i++) begin
      r_op[i]   = (i % 2 == 0) ? 4'd10 : 4'd4;
      r_addr[i] = 32'h100 + 32'(4 * (i / 2));
      r_data[i] = 32'hC0DE_0000 | 32'((i / 2) * 16 + 1);
      mem[r_addr[i][11:2]] = 32'h0;
    end
    while (done < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.load_valid === 1'b1) begin
        checks++;
        if (q_load.size() == 0 || q_load[0] !== 1'b1 || bus.load_data !== q_data[0]) begin
          errors++; $display("FAIL b2b_load data=%h pending=%0d required %h",
            bus.load_data, q_load.size(), (q_data.size() != 0) ? q_data[0] : 32'h0);
        end
        if (q_load.size() != 0) begin void'(q_load.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front()); end
        done++;
      end
      if (bus.store_done === 1'b1) begin
        checks++;
        if (q_load.size() == 0 || q_load[0] !== 1'b0 || mem[q_addr[0][11:2]] !== q_data[0]) begin
          errors++; $display("FAIL b2b_store word=%h pending=%0d required %h",
            (q_addr.size() != 0) ? mem[q_addr[0][11:2]] : 32'h0, q_load.size(),
            (q_data.size() != 0) ? q_data[0] : 32'h0);
        end
        if (q_load.size() != 0) begin void'(q_load.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front()); end
        done++;
      end
      if (idx < 8) begin
        bus.req_valid = 1'b1; bus.req_op = r_op[idx]; bus.req_address = r_addr[idx];
        bus.req_store_data = r_data[idx]; bus.req_rt_old = 32'h0;
        if (bus.req_ready === 1'b1) begin
          q_load.push_back(r_op[idx] == 4'd4);
          q_addr.push_back(r_addr[idx]);
          q_data.push_back(r_data[idx]);
          idx++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done != 8 || idx != 8 || q_load.size() != 0 || bus.load_valid !== 1'b0 || bus.store_done !== 1'b0) begin
      errors++; $display("FAIL b2b_count completed=%0d issued=%0d pending=%0d required 8 8 0",
        done, idx, q_load.size());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_viol != 0) begin
      errors++; $display("FAIL invariants violations=%0d required 0", n_viol);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_address = 32'h0;
    bus.req_store_data = 32'h0; bus.req_rt_old = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #2 reset = 1'b0;
    test_reset();
    test_loads();
    test_rmw_store();
    test_lwl_lwr();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
